// File: rtl/dsi_pkg.sv
// Shared constants and state type for the DSI pixel feeder.
package dsi_pkg;

    localparam int                 PIXEL_W     = 24;
    localparam logic [PIXEL_W-1:0] BLANK_PIXEL = 24'h000000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRIME  = 2'd1,
        STREAM = 2'd2
    } feeder_state_t;

endpackage

// File: rtl/dsi_sync_fifo.sv
// Single-clock FIFO, DEPTH x W, with registered occupancy and full/empty flags.
module dsi_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 24
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             wr_data,
    input  logic                     pop,
    output logic [W-1:0]             rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full    = (count_q == LW'(DEPTH));
    assign empty   = (count_q == '0);
    assign level   = count_q;
    assign rd_data = mem_q[rd_ptr_q];

    // Guards make the FIFO safe even if a caller pushes when full or pops when empty.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (do_push && !do_pop)      count_d = count_q + 1'b1;
        else if (do_pop && !do_push) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/dsi_pixel_feeder.sv
// Buffers RGB pixels and presents one per serializer slot; blank on underflow.
// Optional DSI_FEEDER_UNDERFLOW_CNT_EN adds a saturating underflow_count output.
//
//   state  | meaning
//   IDLE   | not streaming, output blank, slot counter held at 0
//   PRIME  | waiting for FIFO to reach PRIME_LEVEL before first slot
//   STREAM | one pixel per SLOT_CYCLES clocks, blank if FIFO empty at load
module dsi_pixel_feeder
    import dsi_pkg::*;
#(
    parameter int                 DEPTH       = 16,
    parameter int                 SLOT_CYCLES = 24,
    parameter int                 PRIME_LEVEL = 4,
    parameter logic [PIXEL_W-1:0] BLANK_PIX   = BLANK_PIXEL
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     run,
    input  logic                     in_valid,
    input  logic [PIXEL_W-1:0]       in_pixel,
    output logic                     in_ready,
    output logic [PIXEL_W-1:0]       pixel_data_out,
    output logic                     slot_start,
    output logic [$clog2(DEPTH):0]   fill_level,
    output logic                     underflow
`ifdef DSI_FEEDER_UNDERFLOW_CNT_EN
    ,output logic [15:0]             underflow_count
`endif
);

    localparam int                LW        = $clog2(DEPTH) + 1;
    localparam int                CW        = $clog2(SLOT_CYCLES);
    localparam logic [CW-1:0]     SLOT_LAST = CW'(SLOT_CYCLES - 1);
    localparam logic [LW-1:0]     PRIME_LVL = LW'(PRIME_LEVEL);

    feeder_state_t      state_q, state_d;
    logic [CW-1:0]      slot_cnt_q, slot_cnt_d;
    logic [PIXEL_W-1:0] pix_q, pix_d;
    logic               slot_start_q, slot_start_d;
    logic               underflow_q, underflow_d;

    logic               fifo_pop, fifo_full, fifo_empty;
    logic [PIXEL_W-1:0] fifo_head;
    logic [LW-1:0]      fifo_level;

    dsi_sync_fifo #(
        .DEPTH (DEPTH),
        .W     (PIXEL_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (in_valid && !fifo_full),
        .wr_data (in_pixel),
        .pop     (fifo_pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    assign in_ready       = !fifo_full;
    assign fill_level     = fifo_level;
    assign pixel_data_out = pix_q;
    assign slot_start     = slot_start_q;
    assign underflow      = underflow_q;

    always_comb begin
        state_d      = state_q;
        slot_cnt_d   = slot_cnt_q;
        pix_d        = pix_q;
        slot_start_d = 1'b0;
        underflow_d  = 1'b0;
        fifo_pop     = 1'b0;
        case (state_q)
            IDLE: begin
                slot_cnt_d = '0;
                pix_d      = BLANK_PIX;
                if (run) state_d = PRIME;
            end
            PRIME: begin
                slot_cnt_d = '0;
                pix_d      = BLANK_PIX;
                if (!run) begin
                    state_d = IDLE;
                end else if (fifo_level >= PRIME_LVL) begin
                    state_d      = STREAM;
                    fifo_pop     = 1'b1;
                    pix_d        = fifo_head;
                    slot_start_d = 1'b1;
                end
            end
            STREAM: begin
                if (slot_cnt_q == SLOT_LAST) begin
                    slot_cnt_d = '0;
                    if (!run) begin
                        state_d = IDLE;
                        pix_d   = BLANK_PIX;
                    end else if (!fifo_empty) begin
                        fifo_pop     = 1'b1;
                        pix_d        = fifo_head;
                        slot_start_d = 1'b1;
                    end else begin
                        // Keep the slot cadence on underflow; no re-prime.
                        pix_d        = BLANK_PIX;
                        underflow_d  = 1'b1;
                        slot_start_d = 1'b1;
                    end
                end else begin
                    slot_cnt_d = slot_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d    = IDLE;
                slot_cnt_d = '0;
                pix_d      = BLANK_PIX;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            slot_cnt_q   <= '0;
            pix_q        <= BLANK_PIX;
            slot_start_q <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            slot_cnt_q   <= slot_cnt_d;
            pix_q        <= pix_d;
            slot_start_q <= slot_start_d;
            underflow_q  <= underflow_d;
        end
    end

`ifdef DSI_FEEDER_UNDERFLOW_CNT_EN
    logic [15:0] ucnt_q, ucnt_d;

    // Counts alongside the pulse so the value is current while underflow is high.
    always_comb begin
        ucnt_d = ucnt_q;
        if (underflow_d && (ucnt_q != 16'hFFFF)) ucnt_d = ucnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ucnt_q <= '0;
        else     ucnt_q <= ucnt_d;
    end

    assign underflow_count = ucnt_q;
`endif

endmodule

// File: tb/tb_dsi_pixel_feeder.sv
// Directed self-checking bench for dsi_pixel_feeder (default parameters).
module tb_dsi_pixel_feeder;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic        in_valid;
    logic [23:0] in_pixel;
    logic        in_ready;
    logic [23:0] pixel_data_out;
    logic        slot_start;
    logic [4:0]  fill_level;
    logic        underflow;
`ifdef DSI_FEEDER_UNDERFLOW_CNT_EN
    logic [15:0] underflow_count;
`endif

    int total = 0;
    int bad   = 0;
    int midchg;

    dsi_pixel_feeder dut (
        .clk            (clk),
        .rst            (rst),
        .run            (run),
        .in_valid       (in_valid),
        .in_pixel       (in_pixel),
        .in_ready       (in_ready),
        .pixel_data_out (pixel_data_out),
        .slot_start     (slot_start),
        .fill_level     (fill_level),
        .underflow      (underflow)
`ifdef DSI_FEEDER_UNDERFLOW_CNT_EN
        ,.underflow_count (underflow_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance until slot_start is seen; n = clocks taken, 0 on timeout.
    task automatic wait_slot(output int n);
        logic [23:0] prev;
        n = 0;
        for (int k = 1; k <= 200; k++) begin
            prev = pixel_data_out;
            tick();
            if (slot_start) begin
                n = k;
                break;
            end
            if (pixel_data_out !== prev) midchg++;
        end
    endtask

    initial begin
        int n;
        midchg   = 0;
        rst      = 1'b1;
        run      = 1'b0;
        in_valid = 1'b0;
        in_pixel = '0;
        repeat (3) tick();
        chk("rst_out",        pixel_data_out, 32'h0);
        chk("rst_fill",       fill_level,     32'd0);
        chk("rst_in_ready",   in_ready,       32'd1);
        chk("rst_slot_start", slot_start,     32'd0);
        chk("rst_underflow",  underflow,      32'd0);
        rst = 1'b0;
        tick();

        // Prime with four pixels while run is high
        run      = 1'b1;
        in_valid = 1'b1;
        in_pixel = 24'h111111; tick();
        in_pixel = 24'h222222; tick();
        in_pixel = 24'h333333; tick();
        in_pixel = 24'h444444; tick();
        in_valid = 1'b0;
        chk("prime_fill4",      fill_level, 32'd4);
        chk("prime_no_slot",    slot_start, 32'd0);
        tick();
        chk("first_slot_start", slot_start,     32'd1);
        chk("first_pixel",      pixel_data_out, 32'h111111);
        chk("first_fill",       fill_level,     32'd3);

        wait_slot(n);
        chk("slot2_period", n,              32'd24);
        chk("slot2_pixel",  pixel_data_out, 32'h222222);
        wait_slot(n);
        chk("slot3_pixel",  pixel_data_out, 32'h333333);
        chk("slot3_uf",     underflow,      32'd0);
        wait_slot(n);
        chk("slot4_pixel",  pixel_data_out, 32'h444444);
        chk("slot4_fill",   fill_level,     32'd0);

        // Drained FIFO: blank slot with underflow, then refill without re-prime
        wait_slot(n);
        chk("slot5_period", n,              32'd24);
        chk("slot5_blank",  pixel_data_out, 32'h0);
        chk("slot5_uf",     underflow,      32'd1);
        in_valid = 1'b1;
        in_pixel = 24'hABCDEF;
        tick();
        in_valid = 1'b0;
        chk("uf_uf_cleared", underflow, 32'd0);
        wait_slot(n);
        chk("refill_period", n,              32'd23);
        chk("refill_pixel",  pixel_data_out, 32'hABCDEF);
        chk("refill_uf",     underflow,      32'd0);

        for (int s = 0; s < 3; s++) begin
            wait_slot(n);
            chk("empty_slot_uf",    underflow,      32'd1);
            chk("empty_slot_blank", pixel_data_out, 32'h0);
        end
`ifdef DSI_FEEDER_UNDERFLOW_CNT_EN
        chk("uf_count", underflow_count, 32'd4);
`endif

        // Drop run mid-slot: current pixel held to slot end, then blank/IDLE
        in_valid = 1'b1;
        in_pixel = 24'h555555; tick();
        in_pixel = 24'h666666; tick();
        in_valid = 1'b0;
        wait_slot(n);
        chk("stop_slot_period", n,              32'd22);
        chk("stop_slot_pixel",  pixel_data_out, 32'h555555);
        chk("stop_slot_fill",   fill_level,     32'd1);
        repeat (10) tick();
        run = 1'b0;
        repeat (13) tick();
        chk("stop_hold_pixel", pixel_data_out, 32'h555555);
        tick();
        chk("stop_blank",      pixel_data_out, 32'h0);
        chk("stop_no_slot",    slot_start,     32'd0);
        chk("stop_fill_kept",  fill_level,     32'd1);
        repeat (30) begin
            tick();
            if (slot_start !== 1'b0) midchg++;
        end
        chk("mid_slot_changes", midchg, 32'd0);

        // Fill to full while stopped; 17th pixel held upstream
        in_valid = 1'b1;
        for (int i = 0; i < 15; i++) begin
            in_pixel = 24'h700000 + 24'(i);
            tick();
        end
        chk("full_fill",     fill_level, 32'd16);
        chk("full_in_ready", in_ready,   32'd0);
        in_pixel = 24'h999999;
        repeat (3) tick();
        chk("full_held_fill", fill_level, 32'd16);

        // Resume: IDLE -> PRIME -> STREAM, first pop frees room for the 17th
        run = 1'b1;
        wait_slot(n);
        chk("resume_latency", n,              32'd2);
        chk("resume_pixel",   pixel_data_out, 32'h666666);
        chk("resume_fill",    fill_level,     32'd15);
        chk("resume_ready",   in_ready,       32'd1);
        tick();
        in_valid = 1'b0;
        chk("pix17_accepted", fill_level, 32'd16);
        chk("pix17_ready",    in_ready,   32'd0);

        // Async reset mid-slot with pixels buffered
        repeat (5) tick();
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out",      pixel_data_out, 32'h0);
        chk("arst_fill",     fill_level,     32'd0);
        chk("arst_in_ready", in_ready,       32'd1);
        chk("arst_slot",     slot_start,     32'd0);
`ifdef DSI_FEEDER_UNDERFLOW_CNT_EN
        chk("arst_uf_count", underflow_count, 32'd0);
`endif
        run = 1'b0;
        tick();
        rst = 1'b0;
        repeat (30) tick();
        chk("post_rst_idle", slot_start | underflow, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
